// File: rtl/fb_scanout_if.sv
// fb_scanout_if: framebuffer read port plus pixel stream between scanout and its neighbours.
interface fb_scanout_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 20
);
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  re;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  frame_start;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_sol;
  logic                  pix_eof;
  modport master (
    output raddr, re, frame_start, pix_data, pix_valid, pix_sol, pix_eof,
    input  rdata, pix_ready
  );
  modport slave (
    input  raddr, re, frame_start, pix_data, pix_valid, pix_sol, pix_eof,
    output rdata, pix_ready
  );
endinterface

// File: rtl/fb_scanout.sv
// fb_scanout: sweeps the display buffer once per frame into a valid/ready pixel stream.
// Reads are credit-limited into a 2-entry output FIFO and never overlap a buffer swap.
module fb_scanout #(
  parameter int ADDR_WIDTH    = 14,
  parameter int DATA_WIDTH    = 20,
  parameter int FRAME_WORDS   = 16384,
  parameter int LINE_WORDS    = 128,
  parameter int VBLANK_CYCLES = 64
) (
  input  logic          sys_clk,
  input  logic          rst,
  fb_scanout_if.master  bus
);
  localparam int VW = VBLANK_CYCLES > 0 ? $clog2(VBLANK_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH:0] LAST  = (ADDR_WIDTH + 1)'(FRAME_WORDS - 1);
  localparam logic [ADDR_WIDTH:0] LLAST = (ADDR_WIDTH + 1)'(LINE_WORDS - 1);
  localparam logic [VW-1:0]       VLAST = VW'(VBLANK_CYCLES > 0 ? VBLANK_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, START, SCAN, DRAIN, VBLANK} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [ADDR_WIDTH:0]   r_line;
  logic [VW-1:0]         r_vcnt;
  logic                  r_fs;
  logic                  r_inflight;
  logic                  r_sol;
  logic                  r_eof;
  logic [DATA_WIDTH+1:0] r_mem [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_occ;
  logic                  w_pop;
  logic                  w_re;
  logic [2:0]            w_level;

  // level counts words that will occupy the FIFO once the in-flight read lands
  assign w_pop   = (r_occ != 2'd0) && bus.pix_ready;
  assign w_level = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
  assign w_re    = !rst && (r_state == SCAN) && (w_level < 3'd2);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_fs    <= 1'b0;
      r_cnt   <= '0;
      r_line  <= '0;
      r_vcnt  <= '0;
    end else begin
      r_fs <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state <= START;
          r_fs    <= 1'b1;
        end
        START: begin
          r_state <= SCAN;
          r_cnt   <= '0;
          r_line  <= '0;
        end
        SCAN: if (w_re) begin
          r_cnt  <= r_cnt + 1'b1;
          r_line <= r_line == LLAST ? '0 : r_line + 1'b1;
          if (r_cnt == LAST) r_state <= DRAIN;
        end
        DRAIN: if (r_occ == 2'd0 && !r_inflight) begin
          r_vcnt  <= '0;
          r_state <= VBLANK_CYCLES == 0 ? START : VBLANK;
          r_fs    <= VBLANK_CYCLES == 0;
        end
        VBLANK: if (r_vcnt == VLAST) begin
          r_state <= START;
          r_fs    <= 1'b1;
        end else r_vcnt <= r_vcnt + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end

  // tags ride alongside the read so they land in the FIFO with their data
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_sol      <= 1'b0;
      r_eof      <= 1'b0;
      r_occ      <= 2'd0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
    end else begin
      r_inflight <= w_re;
      if (w_re) begin
        r_sol <= r_line == '0;
        r_eof <= r_cnt == LAST;
      end
      if (r_inflight) begin
        r_mem[r_wptr] <= {bus.rdata, r_sol, r_eof};
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_occ <= r_occ + 2'(r_inflight) - 2'(w_pop);
    end
  end

  assign bus.raddr       = r_cnt[ADDR_WIDTH-1:0];
  assign bus.re          = w_re;
  assign bus.frame_start = r_fs;
  assign bus.pix_valid   = r_occ != 2'd0;
  assign {bus.pix_data, bus.pix_sol, bus.pix_eof} = r_mem[r_rptr];
endmodule
